// File: rtl/sram_arbiter_if.sv
// One master port of sram_arbiter: request/grant handshake plus synchronous read return.
// The CPU and the DMA engine each get their own instance of this bundle.
interface sram_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/sram_arbiter.sv
// CPU/DMA arbiter for the shared single-port SRAM: CPU priority, locked DMA bursts, read return.
// Define SRAM_ARB_FAIR_EN to cap a locked DMA burst at MAX_BURST grants while the CPU waits.
module sram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave cpu,
  sram_arbiter_if.slave dma,
  input  logic          dma_lock,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic [1:0]    owner
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
    $error("sram_arbiter: MAX_BURST must be in 1..255");
  end

  logic last_dma_reg;
  logic cpu_rvalid_reg;
  logic dma_rvalid_reg;
  logic cpu_gnt;
  logic dma_gnt;
  logic dma_keep;

`ifdef SRAM_ARB_FAIR_EN
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  logic [7:0] burst_cnt_reg;
  logic [7:0] burst_cnt_next;

  // Once the limit is reached the DMA only keeps the port if nobody else wants it.
  assign dma_keep = dma.req & dma_lock & last_dma_reg &
                    ((burst_cnt_reg < BURST_LIMIT) | ~cpu.req);

  always_comb begin
    burst_cnt_next = 8'd0;
    if (dma_gnt) begin
      if (!last_dma_reg) begin
        burst_cnt_next = 8'd1;
      end else if (burst_cnt_reg >= BURST_LIMIT) begin
        burst_cnt_next = BURST_LIMIT;
      end else begin
        burst_cnt_next = burst_cnt_reg + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt_reg <= 8'd0;
    end else begin
      burst_cnt_reg <= burst_cnt_next;
    end
  end
`else
  assign dma_keep = dma.req & dma_lock & last_dma_reg;
`endif

  // Grants are squashed while reset is held so the SRAM sees no access.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst) begin
      if (dma_keep) begin
        dma_gnt = 1'b1;
      end else if (cpu.req) begin
        cpu_gnt = 1'b1;
      end else if (dma.req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    sram_en    = cpu_gnt | dma_gnt;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (cpu_gnt) begin
      sram_we    = cpu.we;
      sram_addr  = cpu.addr;
      sram_wdata = cpu.wdata;
    end else if (dma_gnt) begin
      sram_we    = dma.we;
      sram_addr  = dma.addr;
      sram_wdata = dma.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dma_reg   <= 1'b0;
      cpu_rvalid_reg <= 1'b0;
      dma_rvalid_reg <= 1'b0;
    end else begin
      last_dma_reg   <= dma_gnt;
      cpu_rvalid_reg <= cpu_gnt & ~cpu.we;
      dma_rvalid_reg <= dma_gnt & ~dma.we;
    end
  end

  // Both masters see the raw SRAM output; only the strobe says whose read it is.
  assign cpu.gnt    = cpu_gnt;
  assign cpu.rdata  = sram_rdata;
  assign cpu.rvalid = cpu_rvalid_reg;
  assign dma.gnt    = dma_gnt;
  assign dma.rdata  = sram_rdata;
  assign dma.rvalid = dma_rvalid_reg;
  assign owner      = {dma_gnt, cpu_gnt};

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_sram_arbiter;
  localparam int AW        = 8;
  localparam int DW        = 32;
  localparam int MAX_BURST = 16;
`ifdef SRAM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(AW), .DW(DW)) cpu_bus ();
  sram_arbiter_if #(.AW(AW), .DW(DW)) dma_bus ();

  logic          dma_lock;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic [1:0]    owner;

  sram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_bus),
    .dma        (dma_bus),
    .dma_lock   (dma_lock),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .owner      (owner)
  );

  // Behavioural single-port SRAM with one-cycle registered read.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr[7:2]] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr[7:2]];
    end
  end

  logic [DW-1:0] ref_mem [64];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_bus.req   = 1'b0;
    cpu_bus.we    = 1'b0;
    cpu_bus.addr  = '0;
    cpu_bus.wdata = '0;
    dma_bus.req   = 1'b0;
    dma_bus.we    = 1'b0;
    dma_bus.addr  = '0;
    dma_bus.wdata = '0;
    dma_lock      = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b1; cpu_bus.addr = 8'h44; cpu_bus.wdata = 32'hDEADBEEF;
    dma_bus.req = 1'b1; dma_lock = 1'b1; dma_bus.addr = 8'h10;
    #2;
    chk_cnt++; if ({dma_bus.gnt, cpu_bus.gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {dma_bus.gnt, cpu_bus.gnt}); else pass_cnt++;
    chk_cnt++; if (owner !== 2'b00) $display("FAIL reset_owner: got %b want 00", owner); else pass_cnt++;
    chk_cnt++; if ({sram_en, sram_we} !== 2'b00) $display("FAIL reset_en_we: got %b want 00", {sram_en, sram_we}); else pass_cnt++;
    chk_cnt++; if ({sram_addr, sram_wdata} !== '0) $display("FAIL reset_addr_wdata: got %h/%h want 0/0", sram_addr, sram_wdata); else pass_cnt++;
    next_cycle();
    chk_cnt++; if ({cpu_bus.rvalid, dma_bus.rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {cpu_bus.rvalid, dma_bus.rvalid}); else pass_cnt++;
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    $display("reset: outputs quiet while rst=0");
  endtask

  task automatic test_fill();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic [DW-1:0] d;
      d = $urandom;
      cpu_bus.req = 1'b1; cpu_bus.we = 1'b1; cpu_bus.addr = 8'(i * 4); cpu_bus.wdata = d;
      #2;
      chk_cnt++;
      if ({cpu_bus.gnt, sram_en, sram_we, sram_addr, sram_wdata} !== {3'b111, 8'(i * 4), d}) begin
        $display("FAIL fill_write: addr %h got gnt=%b en=%b we=%b a=%h d=%h want 1 1 1 %h %h",
                 8'(i * 4), cpu_bus.gnt, sram_en, sram_we, sram_addr, sram_wdata, 8'(i * 4), d);
        bad++;
      end else pass_cnt++;
      ref_mem[i] = d;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    $display("fill: 64 CPU writes, %0d bad", bad);
  endtask

  task automatic test_cpu_read();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b1; cpu_bus.addr = 8'h80; cpu_bus.wdata = 32'h01020304;
    ref_mem[32] = 32'h01020304;
    next_cycle();
    cpu_bus.we = 1'b0;
    #2;
    chk_cnt++; if (cpu_bus.gnt !== 1'b1) $display("FAIL cpu_read_gnt: got %b want 1", cpu_bus.gnt); else pass_cnt++;
    chk_cnt++; if (owner !== 2'b01) $display("FAIL cpu_read_owner: got %b want 01", owner); else pass_cnt++;
    next_cycle();
    idle_inputs();
    chk_cnt++; if (cpu_bus.rvalid !== 1'b1) $display("FAIL cpu_read_rvalid: got %b want 1", cpu_bus.rvalid); else pass_cnt++;
    chk_cnt++; if (cpu_bus.rdata !== 32'h01020304) $display("FAIL cpu_read_rdata: got %h want 01020304", cpu_bus.rdata); else pass_cnt++;
    chk_cnt++; if (dma_bus.rvalid !== 1'b0) $display("FAIL cpu_read_dma_rvalid: got %b want 0", dma_bus.rvalid); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (cpu_bus.rvalid !== 1'b0) $display("FAIL cpu_read_single_strobe: got %b want 0", cpu_bus.rvalid); else pass_cnt++;
    $display("cpu_read: addr 80 data %h", 32'h01020304);
  endtask

  task automatic test_simultaneous();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h04;
    dma_bus.req = 1'b1; dma_bus.we = 1'b0; dma_bus.addr = 8'h08;
    #2;
    chk_cnt++; if (owner !== 2'b01) $display("FAIL simul_cycle0_owner: got %b want 01", owner); else pass_cnt++;
    next_cycle();
    cpu_bus.req = 1'b0;
    #2;
    chk_cnt++; if (owner !== 2'b10) $display("FAIL simul_cycle1_owner: got %b want 10", owner); else pass_cnt++;
    next_cycle();
    chk_cnt++; if (dma_bus.rvalid !== 1'b1 || dma_bus.rdata !== ref_mem[2]) $display("FAIL simul_dma_read: got rv=%b d=%h want 1 %h", dma_bus.rvalid, dma_bus.rdata, ref_mem[2]); else pass_cnt++;
    idle_inputs();
    next_cycle();
    $display("simultaneous: CPU then DMA");
  endtask

  task automatic test_burst();
    int cycle = 0;
    int dma_words = 0;
    int cpu_cycle = -1;
    int run_before_cpu = -1;
    int resume_cycle = -1;
    dma_lock = 1'b1;
    dma_bus.we = 1'b0;
    cpu_bus.we = 1'b0;
    cpu_bus.addr = 8'h0C;
    while ((dma_words < 20 || cpu_cycle < 0) && cycle < 60) begin
      dma_bus.req  = (dma_words < 20);
      dma_bus.addr = 8'(dma_words * 4);
      cpu_bus.req  = (cycle >= 2 && cpu_cycle < 0);
      #2;
      if (cpu_bus.gnt) begin
        cpu_cycle = cycle;
        run_before_cpu = dma_words;
      end
      if (dma_bus.gnt) begin
        if (cpu_cycle >= 0 && resume_cycle < 0) resume_cycle = cycle;
        dma_words++;
      end
      next_cycle();
      cycle++;
    end
    idle_inputs();
    chk_cnt++; if (cycle >= 60) $display("FAIL burst_timeout: ran %0d cycles, want < 60", cycle); else pass_cnt++;
    chk_cnt++; if (cpu_cycle !== (FAIR ? MAX_BURST : 20)) $display("FAIL burst_cpu_cycle: got %0d want %0d", cpu_cycle, FAIR ? MAX_BURST : 20); else pass_cnt++;
    chk_cnt++; if (run_before_cpu !== (FAIR ? MAX_BURST : 20)) $display("FAIL burst_run_len: got %0d want %0d", run_before_cpu, FAIR ? MAX_BURST : 20); else pass_cnt++;
    chk_cnt++; if (resume_cycle !== (FAIR ? MAX_BURST + 1 : -1)) $display("FAIL burst_resume: got %0d want %0d", resume_cycle, FAIR ? MAX_BURST + 1 : -1); else pass_cnt++;
    chk_cnt++; if (dma_words !== 20) $display("FAIL burst_words: got %0d want 20", dma_words); else pass_cnt++;
    next_cycle();
    $display("burst: cpu granted at cycle %0d after %0d DMA words", cpu_cycle, run_before_cpu);
  endtask

  task automatic test_copy();
    logic [DW-1:0] captured;
    dma_lock = 1'b1;
    dma_bus.req = 1'b1;
    for (int w = 0; w < 2; w++) begin
      dma_bus.we = 1'b0; dma_bus.addr = 8'(8'h80 + w * 4);
      #2;
      chk_cnt++; if (dma_bus.gnt !== 1'b1) $display("FAIL copy_read_gnt%0d: got %b want 1", w, dma_bus.gnt); else pass_cnt++;
      next_cycle();
      chk_cnt++; if (dma_bus.rvalid !== 1'b1 || dma_bus.rdata !== ref_mem[32 + w]) $display("FAIL copy_read_data%0d: got rv=%b d=%h want 1 %h", w, dma_bus.rvalid, dma_bus.rdata, ref_mem[32 + w]); else pass_cnt++;
      captured = dma_bus.rdata;
      dma_bus.we = 1'b1; dma_bus.addr = 8'(8'hC0 + w * 4); dma_bus.wdata = captured;
      #2;
      chk_cnt++; if ({dma_bus.gnt, sram_we, sram_addr} !== {2'b11, 8'(8'hC0 + w * 4)}) $display("FAIL copy_write%0d: got gnt=%b we=%b a=%h want 1 1 %h", w, dma_bus.gnt, sram_we, sram_addr, 8'(8'hC0 + w * 4)); else pass_cnt++;
      ref_mem[48 + w] = captured;
      next_cycle();
      chk_cnt++; if (dma_bus.rvalid !== 1'b0) $display("FAIL copy_write_no_resp%0d: got %b want 0", w, dma_bus.rvalid); else pass_cnt++;
    end
    idle_inputs();
    next_cycle();
    chk_cnt++; if (mem[48] !== ref_mem[32] || mem[49] !== ref_mem[33]) $display("FAIL copy_final: got %h %h want %h %h", mem[48], mem[49], ref_mem[32], ref_mem[33]); else pass_cnt++;
    $display("copy: 80..87 -> C0..C7");
  endtask

  task automatic test_reset_mid_read();
    dma_bus.req = 1'b1; dma_lock = 1'b1; dma_bus.we = 1'b0; dma_bus.addr = 8'h10;
    #2;
    chk_cnt++; if (dma_bus.gnt !== 1'b1) $display("FAIL rst_mid_gnt: got %b want 1", dma_bus.gnt); else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    #1;
    chk_cnt++; if (dma_bus.rvalid !== 1'b0) $display("FAIL rst_mid_rvalid: got %b want 0", dma_bus.rvalid); else pass_cnt++;
    chk_cnt++; if ({owner, sram_en, dma_bus.gnt, cpu_bus.gnt} !== 5'b0) $display("FAIL rst_mid_grants: got owner=%b en=%b want 00 0", owner, sram_en); else pass_cnt++;
    next_cycle();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h20;
    rst = 1'b1;
    #2;
    chk_cnt++; if ({cpu_bus.gnt, dma_bus.gnt} !== 2'b10) $display("FAIL rst_release_gnt: got cpu=%b dma=%b want 1 0", cpu_bus.gnt, dma_bus.gnt); else pass_cnt++;
    next_cycle();
    idle_inputs();
    chk_cnt++; if ({cpu_bus.rvalid, dma_bus.rvalid} !== 2'b10 || cpu_bus.rdata !== ref_mem[8]) $display("FAIL rst_release_read: got rv=%b%b d=%h want 10 %h", cpu_bus.rvalid, dma_bus.rvalid, cpu_bus.rdata, ref_mem[8]); else pass_cnt++;
    next_cycle();
    $display("reset_mid_read: pending read dropped");
  endtask

  task automatic test_random();
    bit prev_dma = 1'b0;
    int run = 0;
    bit exp_cpu_rv = 1'b0;
    bit exp_dma_rv = 1'b0;
    logic [DW-1:0] exp_data = '0;
    int bad = 0;
    idle_inputs();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      bit keep;
      logic [1:0] exp_owner;
      if (!cpu_bus.req && $urandom_range(0, 2) == 0) begin
        cpu_bus.req = 1'b1; cpu_bus.we = 1'($urandom_range(0, 1));
        cpu_bus.addr = 8'($urandom); cpu_bus.wdata = $urandom;
      end
      if (!dma_bus.req && $urandom_range(0, 3) != 0) begin
        dma_bus.req = 1'b1; dma_bus.we = 1'($urandom_range(0, 1));
        dma_bus.addr = 8'($urandom); dma_bus.wdata = $urandom;
      end
      dma_lock = ($urandom_range(0, 7) != 0);
      #2;
      keep = dma_bus.req && dma_lock && prev_dma && (!FAIR || run < MAX_BURST || !cpu_bus.req);
      exp_owner = keep ? 2'b10 : cpu_bus.req ? 2'b01 : dma_bus.req ? 2'b10 : 2'b00;
      chk_cnt++;
      if ({owner, dma_bus.gnt, cpu_bus.gnt, sram_en} !== {exp_owner, exp_owner, exp_owner != 2'b00}) begin
        $display("FAIL random_grant cyc %0d: got owner=%b gnt=%b%b en=%b want %b", cyc, owner, dma_bus.gnt, cpu_bus.gnt, sram_en, exp_owner);
        bad++;
      end else pass_cnt++;
      exp_cpu_rv = (exp_owner == 2'b01) && !cpu_bus.we;
      exp_dma_rv = (exp_owner == 2'b10) && !dma_bus.we;
      if (exp_owner == 2'b01) begin
        if (cpu_bus.we) ref_mem[cpu_bus.addr[7:2]] = cpu_bus.wdata;
        else exp_data = ref_mem[cpu_bus.addr[7:2]];
      end else if (exp_owner == 2'b10) begin
        if (dma_bus.we) ref_mem[dma_bus.addr[7:2]] = dma_bus.wdata;
        else exp_data = ref_mem[dma_bus.addr[7:2]];
      end
      run = (exp_owner == 2'b10) ? run + 1 : 0;
      prev_dma = (exp_owner == 2'b10);
      next_cycle();
      chk_cnt++;
      if ({cpu_bus.rvalid, dma_bus.rvalid} !== {exp_cpu_rv, exp_dma_rv} ||
          ((exp_cpu_rv || exp_dma_rv) && sram_rdata !== exp_data)) begin
        $display("FAIL random_rvalid cyc %0d: got rv=%b%b d=%h want %b%b %h", cyc, cpu_bus.rvalid, dma_bus.rvalid, sram_rdata, exp_cpu_rv, exp_dma_rv, exp_data);
        bad++;
      end else pass_cnt++;
      if (exp_owner == 2'b01) cpu_bus.req = 1'b0;
      if (exp_owner == 2'b10) dma_bus.req = 1'b0;
    end
    idle_inputs();
    next_cycle();
    $display("random: 1000 cycles, %0d bad", bad);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_cpu_read();
    test_simultaneous();
    test_burst();
    test_copy();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter sharing the single-port SRAM between the MIPS CPU and the DMA engine in `top`. Grants one access per cycle, gives the CPU priority by default, lets the DMA hold the port across a locked copy burst, and (optionally) bounds that burst so the CPU cannot starve. Routes the SRAM's synchronous read data back to whichever master issued the read, with a registered valid strobe.

## Interface
- `AW`, 8: byte-address width (CPU and DMA address space).
- `DW`, 32: data width.
- `MAX_BURST`, 16: maximum consecutive locked DMA grants while the CPU is waiting; range 1..255.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `cpu_req`  in  1  CPU access request; held until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  access issued this cycle.
- `cpu_rdata`  out  DW  read data, valid when `cpu_rvalid`.
- `cpu_rvalid`  out  1  read response strobe.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rdata`, `dma_rvalid`: same meaning/width for the DMA.
- `dma_lock`  in  1  DMA requests to keep the port for its next access.
- `sram_en`  out  1  SRAM access enable.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  AW  SRAM address.
- `sram_wdata`  out  DW  SRAM write data.
- `sram_rdata`  in  DW  SRAM read data, valid one cycle after a read.
- `owner`  out  2  current-cycle grant: 00 none, 01 CPU, 10 DMA.

## Operation
- State: `last_dma` (1 bit, DMA granted last cycle), `burst_cnt` (8 bits, saturating at `MAX_BURST`), `cpu_rvalid`/`dma_rvalid` registers.
- Grant (combinational, evaluated each cycle, in order):
  1. `dma_req & dma_lock & last_dma & (burst_cnt < MAX_BURST | ~cpu_req)` -> DMA.
  2. `cpu_req` -> CPU.
  3. `dma_req` -> DMA.
  4. otherwise none.
- At most one of `cpu_gnt`/`dma_gnt` high; never a grant without the matching request.
- SRAM mux: `sram_en` = any grant; `sram_we`/`sram_addr`/`sram_wdata` from granted master; all 0 when no grant.
- `burst_cnt`: on DMA grant, `last_dma ? sat(burst_cnt+1) : 1`; on any non-DMA cycle, 0. `last_dma` <= `dma_gnt`.
- Read return: `x_rvalid` <= `x_gnt & ~x_we`; `cpu_rdata` and `dma_rdata` both driven by `sram_rdata`; only the strobe selects the consumer.
- Write completes in the grant cycle; no write response.
- Simultaneous first requests (`last_dma`=0): CPU wins, DMA waits.
- CPU request arriving mid-burst: DMA keeps the port until `burst_cnt` reaches `MAX_BURST`, then the CPU gets exactly one cycle; DMA regains on the next cycle only via rule 3 (if CPU drops its request) or via rule 1 after a fresh grant.
- DMA dropping `dma_lock` or `dma_req` ends the burst immediately.

## Timing
- Reset (rst=0, asynchronous): `last_dma`=0, `burst_cnt`=0, `cpu_rvalid`=`dma_rvalid`=0; grants, `sram_en`, `sram_we`, `owner` forced 0 while in reset; `sram_addr`/`sram_wdata` 0.
- Reset mid-read: pending response discarded; no `rvalid` after release.
- Grant latency: 0 cycles (same cycle as request when winning).
- Read latency: `rvalid` and data exactly 1 cycle after grant; back-to-back reads give back-to-back `rvalid`.
- Masters sample `gnt` at the rising edge; request must stay stable until then.

## Configuration
- `SRAM_ARB_FAIR_EN` defined: burst limit active as described.
- Not defined: `burst_cnt` logic removed; rule 1 becomes `dma_req & dma_lock & last_dma`, so a locked DMA burst is unbounded and the CPU waits until lock drops. `MAX_BURST` is ignored.

## Test plan
- CPU read addr 0x80 with SRAM word 0x01020304, DMA idle -> `cpu_gnt` same cycle, `cpu_rvalid`=1 with `cpu_rdata`=0x01020304 next cycle, `dma_rvalid`=0.
- `cpu_req` and `dma_req` both raised in cycle 0 from idle -> CPU granted cycle 0, DMA granted cycle 1 (after CPU drops), `owner` 01 then 10.
- DMA locked burst of 20 words, CPU requests at burst word 3, `MAX_BURST`=16 with macro -> DMA 16 consecutive grants, CPU granted on cycle 17, then DMA resumes; without macro -> CPU granted only after lock drops (after word 20).
- DMA copy 0x80->0xC0, 2 words (read, write, read, write) with lock -> read at 0x80 returns data on `dma_rdata` with `dma_rvalid`; writes to 0xC0/0xC4 reach SRAM; final SRAM 0xC0..0xC7 equals 0x80..0x87.
- Assert `rst`=0 the cycle after a DMA read grant -> `dma_rvalid` stays 0, all grants 0, `burst_cnt`=0; after release, CPU request granted immediately.
- Random req/lock traffic 1000 cycles -> never both grants, never `sram_en` without a grant, every read grant matched by exactly one `rvalid` one cycle later.
